// File: rtl/adj_det_div_pkg.sv
// adj_det_div_pkg
// Shared constants, derived widths and FSM state encoding for the serial
// complex divider (adj_det_div) and its unsigned restoring divider.
// No ports; imported by the interface, the divider and the top level.
package adj_det_div_pkg;

   localparam int IN_W    = 9;    // signed integer input width
   localparam int FRAC    = 6;    // fractional bits of the quotient
   localparam int OUT_W   = 16;   // signed Q(OUT_W-FRAC).FRAC output width
   localparam int DIV_CYC = 24;   // divider iterations = dividend magnitude bits

   localparam int NUM_W = 2 * IN_W + 1;   // signed numerator er*dr + ei*di
   localparam int MAG_W = 2 * IN_W;       // unsigned |det|^2
   localparam int ABS_W = NUM_W - 1;      // |numerator| fits one bit narrower

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PREP,
      DIV,
      OUT
   } state_t;

endpackage

// File: rtl/adj_det_div_if.sv
// adj_det_div_if
// Burst bus between the determinant/adjugate stage, this divider and its
// consumer.
//   in_valid/in_real/in_image    : 5-word input burst (det, e0..e3)
//   out_valid/out_real/out_image : 4-word result burst (e_k/det)
//   out_err                      : det == 0 flag, valid with each output word
// Modports: master = upstream/consumer side, slave = the divider.
interface adj_det_div_if;
   import adj_det_div_pkg::*;

   logic                    in_valid;
   logic signed [IN_W-1:0]  in_real;
   logic signed [IN_W-1:0]  in_image;
   logic                    out_valid;
   logic signed [OUT_W-1:0] out_real;
   logic signed [OUT_W-1:0] out_image;
   logic                    out_err;

   modport master (
      output in_valid, in_real, in_image,
      input  out_valid, out_real, out_image, out_err
   );

   modport slave (
      input  in_valid, in_real, in_image,
      output out_valid, out_real, out_image, out_err
   );

endinterface

// File: rtl/adj_det_div_serial_udiv.sv
// adj_det_div_serial_udiv
// Unsigned radix-2 restoring divider, one quotient bit per clock.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_i     : load dividend/divisor and begin DVD_W iterations
//   dividend_i  : unsigned dividend (DVD_W bits)
//   divisor_i   : unsigned divisor (DVS_W bits)
//   done_o      : high in the cycle performing the final iteration
//   quot_o      : low Q_W quotient bits; final value while done_o is high
// A zero divisor produces a meaningless quotient; the caller masks it.
module adj_det_div_serial_udiv #(
   parameter int DVD_W = 24,
   parameter int DVS_W = 18,
   parameter int Q_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [DVD_W-1:0] dividend_i,
   input  logic [DVS_W-1:0] divisor_i,
   output logic             done_o,
   output logic [Q_W-1:0]   quot_o
);

   localparam int CNT_W = $clog2(DVD_W);

   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DVD_W-1:0] dvd_q, dvd_d;
   logic [DVS_W-1:0] dvs_q, dvs_d;
   logic [DVS_W-1:0] rem_q, rem_d;
   logic [Q_W-2:0]   quot_q, quot_d;   // top quotient bit is only ever needed combinationally

   logic [DVS_W:0]   rem_sh;
   logic             ge;
   logic [Q_W-1:0]   quot_nxt;

   always_comb begin
      rem_sh   = {rem_q, dvd_q[DVD_W-1]};
      ge       = (rem_sh >= {1'b0, dvs_q});
      quot_nxt = {quot_q, ge};

      busy_d = busy_q;
      cnt_d  = cnt_q;
      dvd_d  = dvd_q;
      dvs_d  = dvs_q;
      rem_d  = rem_q;
      quot_d = quot_q;

      if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = CNT_W'(DVD_W - 1);
         dvd_d  = dividend_i;
         dvs_d  = divisor_i;
         rem_d  = '0;
         quot_d = '0;
      end else if (busy_q) begin
         // Remainder stays below the divisor, so it always fits DVS_W bits.
         rem_d  = DVS_W'(ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh);
         dvd_d  = {dvd_q[DVD_W-2:0], 1'b0};
         quot_d = quot_nxt[Q_W-2:0];
         cnt_d  = cnt_q - CNT_W'(1);
         if (cnt_q == '0) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         dvd_q  <= '0;
         dvs_q  <= '0;
         rem_q  <= '0;
         quot_q <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         dvd_q  <= dvd_d;
         dvs_q  <= dvs_d;
         rem_q  <= rem_d;
         quot_q <= quot_d;
      end
   end

   assign done_o = busy_q && (cnt_q == '0);
   assign quot_o = quot_nxt;

endmodule

// File: rtl/adj_det_div.sv
// adj_det_div
// Serial complex divider: takes det and adjugate elements e0..e3 as a
// 5-word burst and returns e_k/det (Q10.6, truncated toward zero) as a
// 4-word burst, 101 cycles after the last input word.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : adj_det_div_if.slave (input burst, output burst, out_err)
// e/det = e*conj(det)/|det|^2; the real and imaginary numerators share the
// |det|^2 divisor and are divided in parallel by two restoring dividers.
module adj_det_div
   import adj_det_div_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   adj_det_div_if.slave bus
);

   state_t state_q, state_d;
   logic [1:0] cnt_q, cnt_d;     // adjugate word index during LOAD
   logic [1:0] k_q, k_d;         // element under division
   logic [1:0] oidx_q, oidx_d;   // next result slot to present; 0 = burst done

   logic signed [IN_W-1:0]  det_r_q, det_r_d, det_i_q, det_i_d;
   logic signed [IN_W-1:0]  e_r_q [4], e_r_d [4];
   logic signed [IN_W-1:0]  e_i_q [4], e_i_d [4];
   logic signed [OUT_W-1:0] res_r_q [4], res_r_d [4];
   logic signed [OUT_W-1:0] res_i_q [4], res_i_d [4];
   logic                    sgn_r_q, sgn_r_d, sgn_i_q, sgn_i_d;

   logic                    out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0] out_real_q, out_real_d;
   logic signed [OUT_W-1:0] out_image_q, out_image_d;
   logic                    out_err_q, out_err_d;

   logic signed [NUM_W-1:0] er_x, ei_x, dr_x, di_x;
   logic signed [NUM_W-1:0] num_r, num_i;
   logic [MAG_W-1:0]        mag;
   logic [DIV_CYC-1:0]      dvd_r, dvd_i;
   logic                    div_start;
   logic                    done_r, done_i;
   logic [OUT_W-1:0]        quot_r, quot_i;
   logic                    det0;

   function automatic logic [ABS_W-1:0] abs_num(input logic signed [NUM_W-1:0] x);
      return ABS_W'(x[NUM_W-1] ? -x : x);
   endfunction

   // Truncation toward zero: the magnitude quotient is already truncated.
   function automatic logic signed [OUT_W-1:0] apply_sign(input logic neg,
                                                          input logic [OUT_W-1:0] m);
      return neg ? -$signed(m) : $signed(m);
   endfunction

   assign det0 = (det_r_q == '0) && (det_i_q == '0);

   // PREP arithmetic: e*conj(det) and |det|^2 for element k
   always_comb begin
      er_x  = NUM_W'(e_r_q[k_q]);
      ei_x  = NUM_W'(e_i_q[k_q]);
      dr_x  = NUM_W'(det_r_q);
      di_x  = NUM_W'(det_i_q);
      num_r = er_x * dr_x + ei_x * di_x;
      num_i = ei_x * dr_x - er_x * di_x;
      mag   = MAG_W'(dr_x * dr_x + di_x * di_x);
      dvd_r = {abs_num(num_r), {FRAC{1'b0}}};
      dvd_i = {abs_num(num_i), {FRAC{1'b0}}};
   end

   adj_det_div_serial_udiv #(
      .DVD_W (DIV_CYC),
      .DVS_W (MAG_W),
      .Q_W   (OUT_W)
   ) u_udiv_re (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (div_start),
      .dividend_i (dvd_r),
      .divisor_i  (mag),
      .done_o     (done_r),
      .quot_o     (quot_r)
   );

   adj_det_div_serial_udiv #(
      .DVD_W (DIV_CYC),
      .DVS_W (MAG_W),
      .Q_W   (OUT_W)
   ) u_udiv_im (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (div_start),
      .dividend_i (dvd_i),
      .divisor_i  (mag),
      .done_o     (done_i),
      .quot_o     (quot_i)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      k_d         = k_q;
      oidx_d      = oidx_q;
      det_r_d     = det_r_q;
      det_i_d     = det_i_q;
      e_r_d       = e_r_q;
      e_i_d       = e_i_q;
      res_r_d     = res_r_q;
      res_i_d     = res_i_q;
      sgn_r_d     = sgn_r_q;
      sgn_i_d     = sgn_i_q;
      out_valid_d = 1'b0;
      out_real_d  = '0;
      out_image_d = '0;
      out_err_d   = 1'b0;
      div_start   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               det_r_d = bus.in_real;
               det_i_d = bus.in_image;
               cnt_d   = '0;
               state_d = LOAD;
            end
         end

         LOAD: begin
            if (bus.in_valid) begin
               e_r_d[cnt_q] = bus.in_real;
               e_i_d[cnt_q] = bus.in_image;
               if (cnt_q == 2'd3) begin
                  k_d     = '0;
                  state_d = PREP;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end else begin
               // Short burst: drop it silently.
               state_d = IDLE;
            end
         end

         PREP: begin
            div_start = 1'b1;
            sgn_r_d   = num_r[NUM_W-1];
            sgn_i_d   = num_i[NUM_W-1];
            state_d   = DIV;
         end

         DIV: begin
            if (done_r && done_i) begin
               // The dividers still run when det == 0 so latency is data-independent.
               res_r_d[k_q] = det0 ? '0 : apply_sign(sgn_r_q, quot_r);
               res_i_d[k_q] = det0 ? '0 : apply_sign(sgn_i_q, quot_i);
               if (k_q == 2'd3) begin
                  out_valid_d = 1'b1;
                  out_real_d  = res_r_q[0];
                  out_image_d = res_i_q[0];
                  out_err_d   = det0;
                  oidx_d      = 2'd1;
                  state_d     = OUT;
               end else begin
                  k_d     = k_q + 2'd1;
                  state_d = PREP;
               end
            end
         end

         OUT: begin
            if (oidx_q == 2'd0) begin
               // Last output word is on the bus; a new burst may start now.
               if (bus.in_valid) begin
                  det_r_d = bus.in_real;
                  det_i_d = bus.in_image;
                  cnt_d   = '0;
                  state_d = LOAD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               out_valid_d = 1'b1;
               out_real_d  = res_r_q[oidx_q];
               out_image_d = res_i_q[oidx_q];
               out_err_d   = det0;
               oidx_d      = oidx_q + 2'd1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         k_q         <= '0;
         oidx_q      <= '0;
         det_r_q     <= '0;
         det_i_q     <= '0;
         e_r_q       <= '{default: '0};
         e_i_q       <= '{default: '0};
         res_r_q     <= '{default: '0};
         res_i_q     <= '{default: '0};
         sgn_r_q     <= 1'b0;
         sgn_i_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_real_q  <= '0;
         out_image_q <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         k_q         <= k_d;
         oidx_q      <= oidx_d;
         det_r_q     <= det_r_d;
         det_i_q     <= det_i_d;
         e_r_q       <= e_r_d;
         e_i_q       <= e_i_d;
         res_r_q     <= res_r_d;
         res_i_q     <= res_i_d;
         sgn_r_q     <= sgn_r_d;
         sgn_i_q     <= sgn_i_d;
         out_valid_q <= out_valid_d;
         out_real_q  <= out_real_d;
         out_image_q <= out_image_d;
         out_err_q   <= out_err_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_real  = out_real_q;
   assign bus.out_image = out_image_q;
   assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_adj_det_div.sv
// tb_adj_det_div
// Directed bench for adj_det_div: each burst pushes its four hand-computed
// results (with the cycle they must appear in) into a queue; a monitor on the
// falling edge pops and compares whenever out_valid is high, and checks that
// outputs are zero whenever out_valid is low or reset is asserted.
module tb_adj_det_div;
   import adj_det_div_pkg::*;

   typedef struct {
      int cyc;
      int re;
      int im;
      bit err;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   fin_req = 1'b0;
   exp_t exp_q[$];
   int   stim[10];   // det_r, det_i, e0_r, e0_i, ... e3_r, e3_i
   int   expv[8];    // w0_r, w0_i, ... w3_r, w3_i (Q10.6 integers)

   adj_det_div_if bus ();

   adj_det_div dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic send(input int nwords, input bit expect_out, input bit err);
      int c;
      for (int i = 0; i < nwords; i++) begin
         @(posedge clk);
         #1;
         bus.in_valid = 1'b1;
         bus.in_real  = IN_W'(stim[2*i]);
         bus.in_image = IN_W'(stim[2*i+1]);
      end
      c = cyc;
      if (expect_out) begin
         for (int j = 0; j < 4; j++) begin
            exp_t e;
            e.cyc = c + 101 + j;
            e.re  = expv[2*j];
            e.im  = expv[2*j+1];
            e.err = err;
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_real  = '0;
      bus.in_image = '0;
   endtask

   // Monitor / scoreboard
   initial begin
      bit fin_seen;
      exp_t e;
      int ar, ai;
      fin_seen = 1'b0;
      forever begin
         @(negedge clk);
         ar = int'(bus.out_real);
         ai = int'(bus.out_image);
         if (!rst_n) begin
            n_chk++;
            if (bus.out_valid !== 1'b0 || ar != 0 || ai != 0 || bus.out_err !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_outputs cyc=%0d: got valid=%b re=%0d im=%0d err=%b, need all 0",
                        cyc, bus.out_valid, ar, ai, bus.out_err);
            end
         end else if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_output cyc=%0d: got re=%0d im=%0d err=%b, need no output",
                        cyc, ar, ai, bus.out_err);
            end else begin
               e = exp_q.pop_front();
               n_chk++;
               if (cyc != e.cyc) begin
                  n_fail++;
                  $display("FAIL out_cycle: got cycle %0d, need %0d", cyc, e.cyc);
               end
               n_chk++;
               if (ar != e.re) begin
                  n_fail++;
                  $display("FAIL out_real cyc=%0d: got %0d, need %0d", cyc, ar, e.re);
               end
               n_chk++;
               if (ai != e.im) begin
                  n_fail++;
                  $display("FAIL out_image cyc=%0d: got %0d, need %0d", cyc, ai, e.im);
               end
               n_chk++;
               if (bus.out_err !== e.err) begin
                  n_fail++;
                  $display("FAIL out_err cyc=%0d: got %b, need %b", cyc, bus.out_err, e.err);
               end
            end
         end else begin
            n_chk++;
            if (bus.out_valid !== 1'b0 || ar != 0 || ai != 0 || bus.out_err !== 1'b0) begin
               n_fail++;
               $display("FAIL idle_outputs cyc=%0d: got valid=%b re=%0d im=%0d err=%b, need all 0",
                        cyc, bus.out_valid, ar, ai, bus.out_err);
            end
         end
         if (fin_req && !fin_seen) begin
            fin_seen = 1'b1;
            n_chk++;
            if (exp_q.size() != 0) begin
               n_fail++;
               $display("FAIL missing_outputs: got %0d words still pending, need 0", exp_q.size());
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test by cycle %0d, need finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_real  = '0;
      bus.in_image = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // det = 2, e0 = 3: 3/2 = 1.5 -> 96
      stim = '{2, 0, 3, 0, 0, 0, 0, 0, 0, 0};
      expv = '{96, 0, 0, 0, 0, 0, 0, 0};
      send(5, 1'b1, 1'b0);
      repeat (110) @(posedge clk);

      // det = 1+1j, e0 = 2: 1-1j
      stim = '{1, 1, 2, 0, 0, 0, 0, 0, 0, 0};
      expv = '{64, -64, 0, 0, 0, 0, 0, 0};
      send(5, 1'b1, 1'b0);
      repeat (110) @(posedge clk);

      // det = 3, e0 = -1: -21.33 truncates to -21
      stim = '{3, 0, -1, 0, 0, 0, 0, 0, 0, 0};
      expv = '{-21, 0, 0, 0, 0, 0, 0, 0};
      send(5, 1'b1, 1'b0);
      repeat (110) @(posedge clk);

      // det = 1, range extremes
      stim = '{1, 0, -256, -256, 255, 255, 0, 0, -1, 0};
      expv = '{-16384, -16384, 16320, 16320, 0, 0, -64, 0};
      send(5, 1'b1, 1'b0);
      repeat (110) @(posedge clk);

      // det = 1+2j: (3+4j)->(140,-25), -7->(-89,179), 1j->(25,12), (5-5j)->(-64,-192)
      stim = '{1, 2, 3, 4, -7, 0, 0, 1, 5, -5};
      expv = '{140, -25, -89, 179, 25, 12, -64, -192};
      send(5, 1'b1, 1'b0);
      repeat (110) @(posedge clk);

      // det = 0: zeros with out_err on every word
      stim = '{0, 0, 5, 0, 1, 1, -3, 2, 7, -7};
      expv = '{0, 0, 0, 0, 0, 0, 0, 0};
      send(5, 1'b1, 1'b1);
      repeat (110) @(posedge clk);

      // Short burst (3 words) must be dropped, then a full burst works
      stim = '{9, 9, 9, 9, 9, 9, 0, 0, 0, 0};
      send(3, 1'b0, 1'b0);
      repeat (150) @(posedge clk);
      stim = '{2, 0, 3, 0, 0, 0, 0, 0, -1, 0};
      expv = '{96, 0, 0, 0, 0, 0, -32, 0};
      send(5, 1'b1, 1'b0);
      repeat (110) @(posedge clk);

      // Reset pulse during DIV: no output from the aborted burst
      stim = '{1, 2, 3, 4, -7, 0, 0, 1, 5, -5};
      send(5, 1'b0, 1'b0);
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (150) @(posedge clk);
      stim = '{1, 1, 2, 0, 0, 0, 0, 0, 0, 0};
      expv = '{64, -64, 0, 0, 0, 0, 0, 0};
      send(5, 1'b1, 1'b0);
      repeat (110) @(posedge clk);

      // Back-to-back: second burst's det arrives in the last output cycle
      stim = '{3, 0, -1, 0, 0, 0, 0, 0, 0, 0};
      expv = '{-21, 0, 0, 0, 0, 0, 0, 0};
      send(5, 1'b1, 1'b0);
      repeat (102) @(posedge clk);
      stim = '{1, 2, 3, 4, -7, 0, 0, 1, 5, -5};
      expv = '{140, -25, -89, 179, 25, 12, -64, -192};
      send(5, 1'b1, 1'b0);
      repeat (115) @(posedge clk);

      fin_req = 1'b1;
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
